// File: rtl/soc_led_pio_pkg.sv
// Purpose: shared register map and PWM constants for the LED/GPIO output PIO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package soc_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUTSET   = 3'd1;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd2;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE = 3'd4;
    localparam logic [2:0] ADDR_DUTY     = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam int              DUTY_W    = 8;
    localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/soc_led_pio_pwm_gen.sv
// Purpose: prescaler tick, 8-bit PWM counter and blink phase shared by all channels.
// Latency: pwm_on is combinational from counter state and duty; counters advance one step per tick.
// Backpressure: none; free-running, restarted by presc_load.
module soc_led_pio_pwm_gen
    import soc_led_pio_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [DUTY_W-1:0]  duty,
    input  logic               presc_load,
    output logic               pwm_on,
    output logic               blink_phase,
    output logic [DUTY_W-1:0]  pwm_cnt
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic               blink_q, blink_d;
    logic               tick;

    // presc_cnt never exceeds prescale: prescale only changes together with a load
    assign tick = (presc_cnt_q == prescale);

    // Counter advance; a prescale load restarts the PWM period but leaves blink phase alone
    always_comb begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d   = pwm_cnt_q;
        blink_d     = blink_q;
        if (presc_load) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                blink_d = ~blink_q;
            end
        end
    end

    // Counter state registers; blink phase starts in the lit half
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            blink_q     <= 1'b1;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign pwm_on      = (duty == DUTY_FULL) | (pwm_cnt_q < duty);
    assign blink_phase = blink_q;
    assign pwm_cnt     = pwm_cnt_q;

endmodule

// File: rtl/soc_system_led_pio_pwm.sv
// Purpose: Avalon-MM output PIO with set/clear aliases, per-channel blink and global PWM dimming.
// Latency: zero-wait-state reads; out_port combinational from registers, or +1 cycle with LED_PIO_OUT_REG_EN.
// Backpressure: none; every access completes in the cycle it is presented.
module soc_system_led_pio_pwm
    import soc_led_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               PRESC_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   blink_en_q, blink_en_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic               wr;
    logic               presc_load;
    logic               pwm_on;
    logic               blink_phase;
    logic [DUTY_W-1:0]  pwm_cnt;
    logic [WIDTH-1:0]   out_comb;
    logic               unused_wdata;

    assign wr         = chipselect & ~write_n;
    assign presc_load = wr & (address == ADDR_PRESCALE);
    // Upper writedata bits beyond the register widths are intentionally dropped
    assign unused_wdata = ^writedata;

    // Register write decode, including atomic set/clear aliases of DATA
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d     = writedata[WIDTH-1:0];
                ADDR_OUTSET:   data_d     = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d     = data_q & ~writedata[WIDTH-1:0];
                ADDR_BLINK_EN: blink_en_d = writedata[WIDTH-1:0];
                ADDR_PRESCALE: prescale_d = writedata[PRESC_W-1:0];
                ADDR_DUTY:     duty_d     = writedata[DUTY_W-1:0];
                default:       ;
            endcase
        end
    end

    // Control/status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            prescale_q <= '0;
            duty_q     <= DUTY_FULL;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
        end
    end

    // Zero-extended read mux; alias and reserved addresses read as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]   = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]   = blink_en_q;
            ADDR_PRESCALE: readdata[PRESC_W-1:0] = prescale_q;
            ADDR_DUTY:     readdata[DUTY_W-1:0]  = duty_q;
            ADDR_STATUS: begin
                readdata[0]    = blink_phase;
                readdata[15:8] = pwm_cnt;
            end
            default:       ;
        endcase
    end

    soc_led_pio_pwm_gen #(
        .PRESC_W (PRESC_W)
    ) u_pwm_gen (
        .clk         (clk),
        .reset       (reset),
        .prescale    (prescale_q),
        .duty        (duty_q),
        .presc_load  (presc_load),
        .pwm_on      (pwm_on),
        .blink_phase (blink_phase),
        .pwm_cnt     (pwm_cnt)
    );

    assign out_comb = data_q & {WIDTH{pwm_on}} & (~blink_en_q | {WIDTH{blink_phase}});

`ifdef LED_PIO_OUT_REG_EN
    logic [WIDTH-1:0] out_q;

    // Retimed pin drive so pad outputs never glitch on decode/compare settling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= out_comb;
        end
    end

    assign out_port = out_q;
`else
    assign out_port = out_comb;
`endif

endmodule

// File: tb/tb_soc_system_led_pio_pwm.sv
module tb_soc_system_led_pio_pwm;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    always #5 clk = ~clk;

    soc_system_led_pio_pwm #(
        .WIDTH       (WIDTH),
        .PRESC_W     (PRESC_W),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    typedef struct {
        logic [7:0]  out_exp;
        logic [31:0] rd_exp;
        logic [2:0]  addr;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: registers plus "edges since last prescale load"; PWM count
    // and blink phase are derived arithmetically from that elapsed count.
    logic [7:0] m_data, m_blen, m_duty, m_outq;
    int         m_presc;
    longint     m_cyc;
    logic       m_base;

    function automatic logic [7:0] m_pwm();
        return 8'((m_cyc / longint'(m_presc + 1)) % 256);
    endfunction

    function automatic logic m_blink();
        longint ticks;
        ticks = m_cyc / longint'(m_presc + 1);
        return m_base ^ (((ticks / 256) % 2) == 1);
    endfunction

    function automatic logic [7:0] m_comb_out();
        logic [7:0] r;
        logic       on;
        on = (m_duty == 8'hFF) || (m_pwm() < m_duty);
        for (int i = 0; i < 8; i++)
            r[i] = m_data[i] & on & (!m_blen[i] | m_blink());
        return r;
    endfunction

    function automatic logic [7:0] m_exp_out();
`ifdef LED_PIO_OUT_REG_EN
        return m_outq;
`else
        return m_comb_out();
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r = {24'd0, m_data};
            3'd3: r = {24'd0, m_blen};
            3'd4: r = 32'(m_presc);
            3'd5: r = {24'd0, m_duty};
            3'd6: r = {16'd0, m_pwm(), 7'd0, m_blink()};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic m_reset();
        m_data = 8'h00; m_blen = 8'h00; m_duty = 8'hFF; m_outq = 8'h00;
        m_presc = 0; m_cyc = 0; m_base = 1'b1;
    endtask

    task automatic m_edge(input logic w, input logic [2:0] a, input logic [31:0] wd);
        m_outq = m_comb_out();
        if (w && a == 3'd4) begin
            m_base  = m_blink();
            m_presc = int'(wd[15:0]);
            m_cyc   = 0;
        end else begin
            m_cyc++;
            if (w) begin
                case (a)
                    3'd0: m_data = wd[7:0];
                    3'd1: m_data = m_data | wd[7:0];
                    3'd2: m_data = m_data & ~wd[7:0];
                    3'd3: m_blen = wd[7:0];
                    3'd5: m_duty = wd[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    // One bus cycle: drive, enqueue expectation for the pre-edge state, advance model at the edge
    task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        e.out_exp = m_exp_out();
        e.rd_exp  = m_read(a);
        e.addr    = a;
        sbq.push_back(e);
        @(posedge clk);
        m_edge(cs & ~wn, a, wd);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        bus(1'b1, 1'b1, a, $urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            bus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    endtask

    // Monitor: compare every presented output against the queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (out_port !== e.out_exp) begin
                    errors++;
                    $display("FAIL out_port act=%h exp=%h t=%0t", out_port, e.out_exp, $time);
                end
                checks++;
                if (readdata !== e.rd_exp) begin
                    errors++;
                    $display("FAIL readdata addr=%0d act=%h exp=%h t=%0t", e.addr, readdata, e.rd_exp, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] wd;
        logic [2:0]  a;
        bit          found;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        rd(3'd0); rd(3'd5); rd(3'd6); rd(3'd3); rd(3'd4); rd(3'd7);

        // DATA / OUTSET / OUTCLEAR sequence
        wr(3'd0, 32'hFFFF_FFA5); rd(3'd0);
        wr(3'd1, 32'h1234_560A); rd(3'd0); rd(3'd1);
        wr(3'd2, 32'h0000_0081); rd(3'd0); rd(3'd2);
        wr(3'd7, 32'hFFFF_FFFF); rd(3'd7); rd(3'd0);
        wr(3'd6, 32'hFFFF_FFFF); rd(3'd6);

        // PWM duty 0x40, then duty 0
        wr(3'd0, 32'hFF); wr(3'd4, 32'h0); wr(3'd5, 32'h40);
        idle(520);
        wr(3'd5, 32'h00);
        idle(300);

        // Blink on bit0 only
        wr(3'd5, 32'hFF); wr(3'd0, 32'h03); wr(3'd3, 32'h01); wr(3'd4, 32'h0);
        idle(600);

        // Prescale reload mid-count
        idle(37);
        wr(3'd4, 32'h3);
        for (int k = 0; k < 24; k++) rd(3'd6);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 12) begin
                a  = 3'($urandom_range(0, 7));
                wd = $urandom;
                if (a == 3'd4) wd[15:0] = 16'($urandom_range(0, 3));
                if (a == 3'd5 && $urandom_range(0, 1) == 1)
                    wd[7:0] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                wr(a, wd);
            end else if ($urandom_range(0, 1) == 1) begin
                rd(3'($urandom_range(0, 7)));
            end else begin
                idle(1);
            end
        end

        // Reset asserted mid-operation with all outputs lit in blink mode
        wr(3'd0, 32'hFF); wr(3'd3, 32'hFF); wr(3'd5, 32'hFF); wr(3'd4, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (m_blink() && m_exp_out() == 8'hFF) found = 1'b1;
            else idle(1);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL blink_wait bound expired act=%h exp=ff", m_exp_out());
        end
        chipselect = 1'b0;
        #3 reset = 1'b1;
        #1;
        checks++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL async_reset out_port act=%h exp=00", out_port);
        end
        m_reset();
        #6 reset = 1'b0;
        for (int k = 0; k < 8; k++) rd(3'(k));
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
